// File: rtl/mcu_bus_pkg.sv
// Shared data-bus definitions: FSM state encoding, rw encoding and the
// default I/O base address used by the ROM/assembler memory map.
package mcu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_WAIT = 2'd1,
      RESP     = 2'd2
   } bus_state_e;

   localparam logic BUS_READ  = 1'b0;
   localparam logic BUS_WRITE = 1'b1;

   localparam logic [7:0] IO_BASE_DEFAULT = 8'hF0;

   // Wide enough for the largest supported RAM latency (15).
   localparam int unsigned WAIT_CW = 4;

endpackage

// File: rtl/mcu_io_regs.sv
// Memory-mapped output register bank: decodes the I/O index, applies the
// write strobe, provides the read mux and flags unmapped indices.
module mcu_io_regs
   import mcu_bus_pkg::*;
#(
   parameter int unsigned     DW      = 8,
   parameter int unsigned     AW      = 8,
   parameter int unsigned     NPORTS  = 4,
   parameter logic [AW-1:0]   IO_BASE = AW'(IO_BASE_DEFAULT)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 wr_en_i,
   input  logic [AW-1:0]        addr_i,
   input  logic [DW-1:0]        wdata_i,
   output logic [DW-1:0]        rdata_o,
   output logic                 unmapped_o,
   output logic [NPORTS*DW-1:0] port_o
);

   logic [AW-1:0] idx;
   logic [DW-1:0] port_q [NPORTS];
   logic [DW-1:0] port_d [NPORTS];

   // Index relative to the start of the I/O window.
   always_comb begin
      idx = addr_i - IO_BASE;
   end

   // Read mux and mapped/unmapped decode.
   always_comb begin
      rdata_o    = '0;
      unmapped_o = 1'b1;
      for (int unsigned k = 0; k < NPORTS; k++) begin
         if (idx == AW'(k)) begin
            rdata_o    = port_q[k];
            unmapped_o = 1'b0;
         end
      end
   end

   // Next-state of the register bank; unmapped writes fall through untouched.
   always_comb begin
      for (int unsigned k = 0; k < NPORTS; k++) begin
         port_d[k] = port_q[k];
         if (wr_en_i && (idx == AW'(k))) begin
            port_d[k] = wdata_i;
         end
      end
   end

   // Register bank storage with synchronous reset.
   always_ff @(posedge clk_i) begin
      for (int unsigned k = 0; k < NPORTS; k++) begin
         if (reset_i) begin
            port_q[k] <= '0;
         end else begin
            port_q[k] <= port_d[k];
         end
      end
   end

   // Flatten the bank: port k occupies bits [k*DW +: DW].
   always_comb begin
      for (int unsigned k = 0; k < NPORTS; k++) begin
         port_o[k*DW +: DW] = port_q[k];
      end
   end

endmodule

// File: rtl/mcu_dbus_ctrl.sv
// Data-bus controller between the CPU data port and data RAM: decodes RAM
// versus memory-mapped output ports, inserts RAM wait states and returns a
// one-cycle ready pulse per access. All outputs are registered.
// Optional: define MCU_BUS_ERR_EN to add the sticky bus_err output, set on
// any access to an unmapped I/O address.
module mcu_dbus_ctrl
   import mcu_bus_pkg::*;
#(
   parameter int unsigned     DW      = 8,
   parameter int unsigned     AW      = 8,
   parameter int unsigned     NPORTS  = 4,
   parameter logic [AW-1:0]   IO_BASE = AW'(IO_BASE_DEFAULT),
   parameter int unsigned     RAM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic                 cpu_rw,
   input  logic [AW-1:0]        cpu_addr,
   input  logic [DW-1:0]        cpu_wdata,
   output logic [DW-1:0]        cpu_rdata,
   output logic                 cpu_ready,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_wdata,
   input  logic [DW-1:0]        ram_rdata,
`ifdef MCU_BUS_ERR_EN
   output logic                 bus_err,
`endif
   output logic [NPORTS*DW-1:0] port_out
);

   if (RAM_LAT < 1 || RAM_LAT > 15) begin : g_bad_ram_lat
      $fatal(1, "mcu_dbus_ctrl: RAM_LAT must be in 1..15");
   end
   if (NPORTS < 1 || NPORTS > 16) begin : g_bad_nports
      $fatal(1, "mcu_dbus_ctrl: NPORTS must be in 1..16");
   end

   bus_state_e         state_q, state_d;
   logic [WAIT_CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0]      cpu_rdata_q, cpu_rdata_d;
   logic               cpu_ready_q, cpu_ready_d;
   logic               ram_en_q, ram_en_d;
   logic               ram_we_q, ram_we_d;
   logic [AW-1:0]      ram_addr_q, ram_addr_d;
   logic [DW-1:0]      ram_wdata_q, ram_wdata_d;

   logic               is_io;
   logic               accept;
   logic               io_wr;
   logic [DW-1:0]      io_rdata;
   logic               io_unmapped;

   always_comb begin
      is_io  = (cpu_addr >= IO_BASE);
      accept = (state_q == IDLE) && cpu_req;
   end

   mcu_io_regs #(
      .DW      (DW),
      .AW      (AW),
      .NPORTS  (NPORTS),
      .IO_BASE (IO_BASE)
   ) u_io_regs (
      .clk_i      (clk),
      .reset_i    (reset),
      .wr_en_i    (io_wr),
      .addr_i     (cpu_addr),
      .wdata_i    (cpu_wdata),
      .rdata_o    (io_rdata),
      .unmapped_o (io_unmapped),
      .port_o     (port_out)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cpu_req) begin
               state_d = is_io ? RESP : RAM_WAIT;
            end
         end
         RAM_WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next-values; registers hold unless the current state updates them.
   always_comb begin
      cnt_d       = cnt_q;
      cpu_rdata_d = cpu_rdata_q;
      cpu_ready_d = 1'b0;
      ram_en_d    = ram_en_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      io_wr       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && is_io) begin
               io_wr       = (cpu_rw == BUS_WRITE);
               cpu_ready_d = 1'b1;
               if (cpu_rw == BUS_READ) begin
                  cpu_rdata_d = io_rdata;
               end
            end else if (accept) begin
               ram_en_d    = 1'b1;
               ram_we_d    = cpu_rw;
               ram_addr_d  = cpu_addr;
               ram_wdata_d = cpu_wdata;
               cnt_d       = WAIT_CW'(RAM_LAT - 1);
            end
         end
         RAM_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (ram_we_q == BUS_READ) begin
                  cpu_rdata_d = ram_rdata;
               end
               ram_en_d    = 1'b0;
               ram_we_d    = 1'b0;
               cpu_ready_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         cpu_rdata_q <= '0;
         cpu_ready_q <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ready_q <= cpu_ready_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   always_comb begin
      cpu_rdata = cpu_rdata_q;
      cpu_ready = cpu_ready_q;
      ram_en    = ram_en_q;
      ram_we    = ram_we_q;
      ram_addr  = ram_addr_q;
      ram_wdata = ram_wdata_q;
   end

`ifdef MCU_BUS_ERR_EN
   logic bus_err_q;

   // Sticky error flag, raised together with the ready pulse of an unmapped access.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_err_q <= 1'b0;
      end else if (accept && is_io && io_unmapped) begin
         bus_err_q <= 1'b1;
      end
   end

   always_comb begin
      bus_err = bus_err_q;
   end
`endif

endmodule
